// File: rtl/ysyx_22041412_mdu_ctrl_pkg.sv
// Shared definitions for the M-extension sequencing controller: FSM states,
// func3 opcodes and multiplier signedness codes.
package ysyx_22041412_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MUL_SIGN_SS = 2'b11;
  localparam logic [1:0] MUL_SIGN_SU = 2'b10;
  localparam logic [1:0] MUL_SIGN_UU = 2'b00;

  function automatic logic [1:0] mul_sign_of(input logic [2:0] func3);
    logic [1:0] s;
    case (func3)
      F3_MULHSU: s = MUL_SIGN_SU;
      F3_MULHU:  s = MUL_SIGN_UU;
      default:   s = MUL_SIGN_SS;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ysyx_22041412_mdu_ctrl_if.sv
// Request/response bus between the pipeline (master) and the MDU controller (slave).
interface ysyx_22041412_mdu_ctrl_if #(
  parameter int XLEN = 64
);
  // Both channels: a beat transfers on the rising edge where valid & ready are
  // high; the sender holds valid and payload stable until that edge.
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_func3;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [4:0]      req_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_tag;

  modport master (
    output req_valid, req_func3, req_word, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_func3, req_word, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/ysyx_22041412_mdu_ctrl_special.sv
// Divide special cases (zero divisor, signed overflow) resolved without the
// divider; purely combinational, W-form ops judged on the low 32 bits.
module ysyx_22041412_mdu_special #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            hit,
  output logic [XLEN-1:0] res
);

  logic [XLEN-1:0] a_eff;
  logic            div_zero;
  logic            ovf;

  always_comb begin
    a_eff    = word ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
    div_zero = word ? (b[31:0] == 32'd0) : (b == '0);
    // Overflow only exists for signed ops: most-negative dividend over -1.
    ovf      = ~func3[0] & (word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                                 : ((a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
    hit      = func3[2] & (div_zero | ovf);
    res      = '0;
    if (div_zero) begin
      res = func3[1] ? a_eff : '1;
    end else if (ovf) begin
      res = func3[1] ? '0 : a_eff;
    end
  end

endmodule

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Sequencer for RISC-V M-extension ops: launches an external multiplier or
// divider, resolves divide corner cases locally, and returns one tagged result.
module ysyx_22041412_mdu_ctrl
  import ysyx_22041412_mdu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ysyx_22041412_mdu_ctrl_if.slave bus,

  output logic                 mul_start,
  output logic [XLEN-1:0]      mul_a,
  output logic [XLEN-1:0]      mul_b,
  output logic                 mul_w,
  output logic [1:0]           mul_sign,
  input  logic                 mul_done,
  input  logic [XLEN-1:0]      mul_hi,
  input  logic [XLEN-1:0]      mul_lo,

  output logic                 div_start,
  output logic [XLEN-1:0]      div_a,
  output logic [XLEN-1:0]      div_b,
  output logic                 div_w,
  output logic                 div_sign,
  output logic                 div_rem,
  input  logic                 div_done,
  input  logic [XLEN-1:0]      div_res,

  output mdu_state_e           dbg_state
);

  mdu_state_e      state_q;
  logic [2:0]      func3_q;
  logic            word_q;
  logic [4:0]      tag_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] rsp_data_q;

  logic            sp_hit;
  logic [XLEN-1:0] sp_res;
  logic            accept;
  logic [XLEN-1:0] mul_sel;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] div_res_x;

  ysyx_22041412_mdu_special #(.XLEN(XLEN)) u_special (
    .func3 (bus.req_func3),
    .word  (bus.req_word),
    .a     (bus.req_a),
    .b     (bus.req_b),
    .hit   (sp_hit),
    .res   (sp_res)
  );

  // Gated by rst so the bus sees not-ready while reset is held.
  assign bus.req_ready = rst & (state_q == ST_IDLE) & ~flush;
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = tag_q;
  assign dbg_state     = state_q;

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign mul_w = word_q;
  assign div_a = a_q;
  assign div_b = b_q;
  assign div_w = word_q;

  always_comb begin
    mul_sel   = (func3_q[1:0] == 2'b00) ? mul_lo : mul_hi;
    mul_res   = word_q ? {{(XLEN-32){mul_sel[31]}}, mul_sel[31:0]} : mul_sel;
    div_res_x = word_q ? {{(XLEN-32){div_res[31]}}, div_res[31:0]} : div_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      func3_q    <= 3'd0;
      word_q     <= 1'b0;
      tag_q      <= 5'd0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      mul_start  <= 1'b0;
      mul_sign   <= 2'b00;
      div_start  <= 1'b0;
      div_sign   <= 1'b0;
      div_rem    <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            func3_q <= bus.req_func3;
            word_q  <= bus.req_word;
            tag_q   <= bus.req_tag;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            if (!bus.req_func3[2]) begin
              state_q   <= ST_MUL;
              mul_start <= 1'b1;
              mul_sign  <= mul_sign_of(bus.req_func3);
            end else if (sp_hit) begin
              state_q    <= ST_DONE;
              rsp_data_q <= sp_res;
            end else begin
              state_q   <= ST_DIV;
              div_start <= 1'b1;
              div_sign  <= ~bus.req_func3[0];
              div_rem   <= bus.req_func3[1];
            end
          end
        end
        ST_MUL: begin
          // A done landing with the flush already ends the op; nothing to drain.
          if (flush) begin
            state_q <= mul_done ? ST_IDLE : ST_DRAIN;
          end else if (mul_done) begin
            rsp_data_q <= mul_res;
            state_q    <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state_q <= div_done ? ST_IDLE : ST_DRAIN;
          end else if (div_done) begin
            rsp_data_q <= div_res_x;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush || bus.rsp_ready) state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (func3_q[2] ? div_done : mul_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Bench for the MDU controller: behavioural mul/div units, a result model from
// the M-extension rules, and a per-cycle response scoreboard.
module tb_ysyx_22041412_mdu_ctrl;
  import ysyx_22041412_mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mul_start, mul_w, mul_done;
  logic [1:0]  mul_sign;
  logic [63:0] mul_a, mul_b, mul_hi, mul_lo;
  logic        div_start, div_w, div_sign, div_rem, div_done;
  logic [63:0] div_a, div_b, div_res;
  mdu_state_e  dbg_state;

  ysyx_22041412_mdu_ctrl_if #(.XLEN(64)) bus ();

  ysyx_22041412_mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_w(mul_w),
    .mul_sign(mul_sign), .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_w(div_w),
    .div_sign(div_sign), .div_rem(div_rem), .div_done(div_done), .div_res(div_res),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [4:0]  tag_q[$];
  int n_mul_start = 0, n_div_start = 0, n_resp = 0, n_drop = 0, n_mul_done = 0;
  int acc_cyc = 0, rise_cyc = 0;
  int unsigned unit_lat = 4;
  logic [63:0] last_data = '0;
  logic [4:0]  last_tag = '0;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [127:0] prod128(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb);
    logic [127:0] x, y;
    x = sa ? {{64{a[63]}}, a} : {64'd0, a};
    y = sb ? {{64{b[63]}}, b} : {64'd0, b};
    return x * y;
  endfunction

  function automatic logic [63:0] div_model(input logic sgn, input logic rem, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, q, r, res, minv;
    if (w) begin
      x = sgn ? sext32(a[31:0]) : {32'd0, a[31:0]};
      y = sgn ? sext32(b[31:0]) : {32'd0, b[31:0]};
      minv = 64'hFFFF_FFFF_8000_0000;
    end else begin
      x = a; y = b;
      minv = 64'h8000_0000_0000_0000;
    end
    if (y == 64'd0) begin
      q = '1; r = x;
    end else if (sgn && x == minv && y == '1) begin
      q = x; r = 64'd0;
    end else if (sgn) begin
      q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
    end else begin
      q = x / y; r = x % y;
    end
    res = rem ? r : q;
    if (w) res = sext32(res[31:0]);
    return res;
  endfunction

  function automatic logic [63:0] exp_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  sel;
    if (!f3[2]) begin
      // MUL/MULH signed*signed, MULHSU signed*unsigned, MULHU unsigned*unsigned
      p   = prod128(a, b, f3[1:0] != 2'b11, f3[1:0] <= 2'b01);
      sel = (f3[1:0] == 2'b00) ? p[63:0] : p[127:64];
      if (w) sel = sext32(sel[31:0]);
    end else begin
      sel = div_model(~f3[0], f3[1], w, a, b);
    end
    return sel;
  endfunction

  // ---------------- behavioural units ----------------
  initial begin
    logic [127:0] p;
    mul_done = 1'b0; mul_hi = '0; mul_lo = '0;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        p = prod128(mul_a, mul_b, mul_sign[1], mul_sign[0]);
        repeat (unit_lat) @(posedge clk);
        #1; mul_hi = p[127:64]; mul_lo = p[63:0]; mul_done = 1'b1;
        @(posedge clk); #1; mul_done = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] r;
    div_done = 1'b0; div_res = '0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) begin
        r = div_model(div_sign, div_rem, div_w, div_a, div_b);
        repeat (unit_lat) @(posedge clk);
        #1; div_res = r; div_done = 1'b1;
        @(posedge clk); #1; div_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mul_start) n_mul_start++;
      if (div_start) n_div_start++;
      if (mul_done)  n_mul_done++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_valid_unexpected actual=1 expected=0 (t=%0t)", $time);
        end else begin
          if (!prev_valid) rise_cyc = cyc;
          chk("rsp_data", bus.rsp_data, exp_q[0]);
          chk("rsp_tag", {59'd0, bus.rsp_tag}, {59'd0, tag_q[0]});
          if (flush) begin
            void'(exp_q.pop_front()); void'(tag_q.pop_front()); n_drop++;
          end else if (bus.rsp_ready) begin
            last_data = bus.rsp_data; last_tag = bus.rsp_tag;
            void'(exp_q.pop_front()); void'(tag_q.pop_front()); n_resp++;
          end
        end
      end
    end
    prev_valid = bus.rsp_valid;
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tag, input bit expect_rsp);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.req_func3 = f3; bus.req_word = w; bus.req_a = a; bus.req_b = b;
    bus.req_tag = tag; bus.req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      acc_cyc = cyc;
      if (expect_rsp) begin
        exp_q.push_back(exp_result(f3, w, a, b));
        tag_q.push_back(tag);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  // lat==0 marks a divide special case: no unit start, 1-cycle latency.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int lat,
                        input int hold, output logic [63:0] data);
    int r0, ms0, ds0;
    bit ok;
    unit_lat = (lat == 0) ? 1 : lat;
    bus.rsp_ready = (hold == 0);
    r0 = n_resp; ms0 = n_mul_start; ds0 = n_div_start;
    send(f3, w, a, b, tag, 1'b1);
    wait_valid(ok);
    chk("rsp_valid_timeout", {63'd0, ok}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("req_ready_in_done", {63'd0, bus.req_ready}, 64'd0);
      chk("rsp_valid_held", {63'd0, bus.rsp_valid}, 64'd1);
      @(negedge clk);
    end
    if (hold > 0) begin @(posedge clk); #1; bus.rsp_ready = 1'b1; end
    for (int i = 0; i < 6; i++) begin
      if (n_resp != r0) break;
      @(negedge clk);
    end
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    chk("handshake", n_resp - r0, 64'd1);
    chk("latency", rise_cyc - acc_cyc, (lat == 0) ? 64'd1 : 64'(lat + 2));
    chk("mul_start_cycles", n_mul_start - ms0, {63'd0, ~f3[2]});
    chk("div_start_cycles", n_div_start - ds0, {63'd0, f3[2] && lat != 0});
    chk("tag_echo", {59'd0, last_tag}, {59'd0, tag});
    data = last_data;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [63:0] d;
    int r0, ds0, d0, md0;
    bit got;
    rst = 1'b0; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_func3 = 3'd0; bus.req_word = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0; bus.rsp_ready = 1'b0;

    // model pins
    chk("pin_mul", exp_result(F3_MUL, 1'b0, 64'd3, -64'sd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("pin_divw_zero", exp_result(F3_DIV, 1'b1, 64'd7, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_remw_ovf", exp_result(F3_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 64'd0);
    chk("pin_divu", exp_result(F3_DIVU, 1'b0, 64'd100, 64'd7), 64'd14);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_starts", {62'd0, mul_start, div_start}, 64'd0);
    chk("rst_operands", mul_a | mul_b | div_a | div_b, 64'd0);
    chk("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

    run_op(F3_MUL, 1'b0, 64'd3, -64'sd5, 5'd9, 4, 0, d);
    chk("mul_3x-5", d, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(F3_DIV, 1'b1, 64'd7, 64'd0, 5'd3, 0, 0, d);
    chk("divw_by_zero", d, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(F3_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd4, 0, 0, d);
    chk("remw_ovf", d, 64'd0);
    run_op(F3_DIVU, 1'b0, 64'd100, 64'd7, 5'd17, 3, 5, d);
    chk("divu_100_7", d, 64'd14);
    run_op(F3_MULH, 1'b0, -64'sd2, 64'd3, 5'd1, 2, 0, d);
    chk("mulh_neg", d, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(F3_MULHU, 1'b0, '1, 64'd2, 5'd2, 5, 0, d);
    chk("mulhu", d, 64'd1);
    run_op(F3_MULHSU, 1'b0, '1, 64'd2, 5'd5, 1, 1, d);
    chk("mulhsu", d, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(F3_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd6, 3, 0, d);
    chk("mulw_sext", d, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(F3_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd7, 0, 0, d);
    chk("div_ovf", d, 64'h8000_0000_0000_0000);
    run_op(F3_REM, 1'b0, -64'sd7, 64'd2, 5'd8, 2, 0, d);
    chk("rem_neg", d, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(F3_DIV, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd10, 4, 2, d);
    chk("divw_neg", d, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(F3_REMU, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'd0, 5'd11, 0, 0, d);
    chk("remuw_zero", d, 64'hFFFF_FFFF_8000_0005);

    // flush two cycles after div_start -> drain until the divider reports
    unit_lat = 8; r0 = n_resp; ds0 = n_div_start;
    send(F3_DIVU, 1'b0, 64'd50, 64'd5, 5'd12, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_div_start != ds0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("flush_div_started", {63'd0, got}, 64'd1);
    @(posedge clk); @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_done) begin got = 1'b1; break; end
      chk("drain_req_ready", {63'd0, bus.req_ready}, 64'd0);
      chk("drain_state", {61'd0, dbg_state}, {61'd0, ST_DRAIN});
    end
    chk("drain_done_seen", {63'd0, got}, 64'd1);
    @(negedge clk);
    chk("after_drain_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("drain_no_rsp", n_resp - r0, 64'd0);
    run_op(F3_DIV, 1'b0, 64'd20, 64'd3, 5'd13, 2, 0, d);
    chk("div_after_drain", d, 64'd6);

    // flush in DONE wins over rsp_ready
    r0 = n_resp; d0 = n_drop; bus.rsp_ready = 1'b0;
    send(F3_DIV, 1'b1, 64'd7, 64'd0, 5'd14, 1'b1);
    wait_valid(got);
    chk("done_flush_valid", {63'd0, got}, 64'd1);
    @(posedge clk); #1; flush = 1'b1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("done_flush_dropped", {63'd0, bus.rsp_valid}, 64'd0);
    chk("done_flush_count", n_drop - d0, 64'd1);
    chk("done_flush_no_hs", n_resp - r0, 64'd0);

    // reset during MUL, stray mul_done afterwards
    unit_lat = 6; ds0 = n_mul_start; md0 = n_mul_done;
    send(F3_MUL, 1'b0, 64'd11, 64'd13, 5'd15, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (n_mul_start != ds0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_mul_started", {63'd0, got}, 64'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    chk("midrst_outputs", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd0);
    chk("midrst_operands", mul_a | {62'd0, mul_sign}, 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stray_done_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    end
    chk("stray_done_seen", n_mul_done - md0, 64'd1);
    chk("stray_done_req_ready", {63'd0, bus.req_ready}, 64'd1);
    run_op(F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 3, 0, d);
    chk("mulhu_after_rst", d, 64'hFFFF_FFFF_FFFF_FFFE);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
